// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor slice.
package bp_pkg;

  // Table entry type; the class exists only to parameterise the struct.
  virtual class bp_entry #(
    parameter int unsigned TAG_W = 1,
    parameter int unsigned TGT_W = 1,
    parameter int unsigned CNT_W = 2
  );
    typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [TGT_W-1:0] target;
      logic [CNT_W-1:0] cnt;
    } entry_t;
  endclass

  // What the resolved instruction does to its table entry.
  typedef enum logic [2:0] {
    UPD_NONE,
    UPD_BR_HIT,
    UPD_BR_ALLOC,
    UPD_JUMP,
    UPD_INVAL
  } upd_kind_e;

  localparam int unsigned CNT_W_MAX = 4;

  // Weakly-taken counter value: 2^(w-1).
  function automatic logic [CNT_W_MAX-1:0] WEAK_T(input int unsigned cnt_w);
    return CNT_W_MAX'(1) << (cnt_w - 1);
  endfunction

  // Weakly-not-taken counter value: 2^(w-1)-1.
  function automatic logic [CNT_W_MAX-1:0] WEAK_NT(input int unsigned cnt_w);
    return (CNT_W_MAX'(1) << (cnt_w - 1)) - CNT_W_MAX'(1);
  endfunction

  function automatic int unsigned idx_w(input int unsigned entries);
    return $clog2(entries);
  endfunction

  function automatic bit is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Next-value logic for one saturating prediction counter.
module sat_counter #(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0] i_cnt,
  input  logic         i_inc,
  input  logic         i_dec,
  input  logic         i_force_max,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_cnt
);

  // Priority: force-max, load, then saturating inc/dec.
  always_comb begin
    o_cnt = i_cnt;
    if (i_force_max) begin
      o_cnt = '1;
    end else if (i_load) begin
      o_cnt = i_load_val;
    end else if (i_inc && (i_cnt != '1)) begin
      o_cnt = i_cnt + 1'b1;
    end else if (i_dec && (i_cnt != '0)) begin
      o_cnt = i_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned CNT_W   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_f,
  output logic            pred_taken_f,
  output logic [XLEN-1:0] pred_target_f,
  input  logic            upd_valid,
  input  logic            upd_is_branch,
  input  logic            upd_is_jump,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  output logic            mispredict_e,
  output logic [XLEN-1:0] redirect_pc_e,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
);

  localparam int unsigned IDX_W = idx_w(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;
  localparam logic [CNT_W-1:0] C_WEAK_T  = CNT_W'(WEAK_T(CNT_W));
  localparam logic [CNT_W-1:0] C_WEAK_NT = CNT_W'(WEAK_NT(CNT_W));

  typedef bp_entry#(.TAG_W(TAG_W), .TGT_W(XLEN), .CNT_W(CNT_W))::entry_t entry_t;

  if (!is_pow2(ENTRIES) || (ENTRIES < 2)) begin : g_bad_entries
    $error("branch_predictor: ENTRIES must be a power of two and at least 2");
  end
  if ((CNT_W < 1) || (CNT_W > CNT_W_MAX)) begin : g_bad_cnt_w
    $error("branch_predictor: CNT_W must be in 1..4");
  end
  if (XLEN <= IDX_W + 2) begin : g_bad_xlen
    $error("branch_predictor: XLEN too small for the table index");
  end

  entry_t          w_tab [ENTRIES];
  logic [IDX_W-1:0] w_idx_f, w_idx_u;
  logic [TAG_W-1:0] w_tag_f, w_tag_u;
  logic             w_hit_f, w_hit_u;
  upd_kind_e        w_kind;
  logic             w_wr_tag, w_wr_target, w_wr_cnt, w_clr;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_unused_pc_lsbs;

  assign w_idx_f = pc_f[IDX_W+1:2];
  assign w_tag_f = pc_f[XLEN-1:IDX_W+2];
  assign w_idx_u = upd_pc[IDX_W+1:2];
  assign w_tag_u = upd_pc[XLEN-1:IDX_W+2];
  assign w_unused_pc_lsbs = ^{pc_f[1:0], upd_pc[1:0]};

  // Fetch lookup reads registered state only, so a same-cycle update is not bypassed.
  always_comb begin
    w_hit_f       = w_tab[w_idx_f].valid && (w_tab[w_idx_f].tag == w_tag_f);
    pred_taken_f  = w_hit_f && w_tab[w_idx_f].cnt[CNT_W-1];
    pred_target_f = pred_taken_f ? w_tab[w_idx_f].target : pc_f + XLEN'(4);
  end

  // Resolve-stage mispredict detection and redirect target.
  always_comb begin
    mispredict_e  = upd_valid && ((upd_pred_taken != upd_taken) ||
                                  (upd_taken && (upd_pred_target != upd_target)));
    redirect_pc_e = upd_taken ? upd_target : upd_pc + XLEN'(4);
  end

  // Classify the update and derive the per-field write enables.
  always_comb begin
    w_hit_u = w_tab[w_idx_u].valid && (w_tab[w_idx_u].tag == w_tag_u);
    w_kind  = UPD_NONE;
    if (upd_valid) begin
      if (upd_is_jump) begin
        w_kind = UPD_JUMP;
      end else if (upd_is_branch) begin
        if (w_hit_u) begin
          w_kind = UPD_BR_HIT;
        end else if (upd_taken) begin
          w_kind = UPD_BR_ALLOC;
        end
      end else if (w_hit_u) begin
        w_kind = UPD_INVAL;
      end
    end
    w_wr_tag    = (w_kind == UPD_JUMP) || (w_kind == UPD_BR_ALLOC);
    w_wr_target = w_wr_tag || ((w_kind == UPD_BR_HIT) && upd_taken);
    w_wr_cnt    = w_wr_tag || (w_kind == UPD_BR_HIT);
    w_clr       = (w_kind == UPD_INVAL);
  end

  sat_counter #(.W(CNT_W)) u_sat_counter (
    .i_cnt       (w_tab[w_idx_u].cnt),
    .i_inc       ((w_kind == UPD_BR_HIT) && upd_taken),
    .i_dec       ((w_kind == UPD_BR_HIT) && !upd_taken),
    .i_force_max (w_kind == UPD_JUMP),
    .i_load      (w_kind == UPD_BR_ALLOC),
    .i_load_val  (C_WEAK_T),
    .o_cnt       (w_cnt_next)
  );

  // Each entry owns its register; w_tab is only a read view for the two lookups.
  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    entry_t r_ent;

    // Entry state: cleared by reset, written when the update index selects it.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_ent.valid  <= 1'b0;
        r_ent.tag    <= '0;
        r_ent.target <= '0;
        r_ent.cnt    <= C_WEAK_NT;
      end else if (w_idx_u == IDX_W'(g)) begin
        if (w_wr_tag) begin
          r_ent.valid <= 1'b1;
          r_ent.tag   <= w_tag_u;
        end
        if (w_clr) begin
          r_ent.valid <= 1'b0;
        end
        if (w_wr_target) begin
          r_ent.target <= upd_target;
        end
        if (w_wr_cnt) begin
          r_ent.cnt <= w_cnt_next;
        end
      end
    end

    assign w_tab[g] = r_ent;
  end

  // Saturating event counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (upd_valid && (upd_is_branch || upd_is_jump) && (perf_branches != '1)) begin
        perf_branches <= perf_branches + 32'd1;
      end
      if (mispredict_e && (perf_mispredicts != '1)) begin
        perf_mispredicts <= perf_mispredicts + 32'd1;
      end
    end
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter XLEN, default 32: address and data width.
REQ-002 SHALL have parameter ENTRIES, default 64: table depth; a power of two, at least 2; IDX_W = log2(ENTRIES).
REQ-003 SHALL have parameter CNT_W, default 2: saturating counter width, 1 to 4.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port pc_f, input, XLEN: fetch-stage PC to predict.
REQ-007 SHALL have port pred_taken_f, output, 1: fetch prediction.
REQ-008 SHALL have port pred_target_f, output, XLEN: predicted next PC.
REQ-009 SHALL have port upd_valid, input, 1: resolved control-flow info present in execute; the pipeline deasserts it for flushed slots.
REQ-010 SHALL have ports upd_is_branch and upd_is_jump, input, 1 each: instruction class.
REQ-011 SHALL have ports upd_pc and upd_target, input, XLEN each: resolved PC and target.
REQ-012 SHALL have port upd_taken, input, 1: actual outcome.
REQ-013 SHALL have ports upd_pred_taken, input, 1, and upd_pred_target, input, XLEN: the prediction piped along with the instruction.
REQ-014 SHALL have ports mispredict_e, output, 1, and redirect_pc_e, output, XLEN: flush request and correct PC.
REQ-015 SHALL have ports perf_branches and perf_mispredicts, output, 32 each: event counters.

Function
REQ-016 SHALL keep per entry: valid, tag = pc[XLEN-1:IDX_W+2], target, and a CNT_W-bit counter; index = pc[IDX_W+1:2].
REQ-017 SHALL make lookup combinational from the table registers: hit = valid and tag match.
- pred_taken_f = hit and counter MSB.
- pred_target_f = stored target if pred_taken_f, else pc_f+4, modulo 2^XLEN.
REQ-018 SHALL, when upd_valid, compute mispredict_e = (upd_pred_taken != upd_taken) or (upd_taken and upd_pred_target != upd_target); otherwise 0.
REQ-019 SHALL drive redirect_pc_e = upd_target if upd_taken, else upd_pc+4.
REQ-020 SHALL, on upd_valid with a branch hit: saturating-increment the counter if taken, else saturating-decrement it; write the target only when taken.
REQ-021 SHALL, on upd_valid with a jump: force the counter to all-ones and write valid, tag and target, whether hit or miss.
REQ-022 SHALL, on a taken branch miss, allocate the entry (overwriting any alias) with counter = 2^(CNT_W-1), weakly taken.
REQ-023 SHALL NOT allocate on a not-taken branch miss.
REQ-024 SHALL, on upd_valid for a non-branch, non-jump instruction that hits, clear that entry's valid bit; mispredict_e follows REQ-018.
REQ-025 SHALL, when lookup and update target the same entry in the same cycle, return pre-update state to the lookup (no bypass); the new state is visible the next cycle.
REQ-026 SHALL increment perf_branches on each upd_valid branch or jump, and perf_mispredicts on each mispredict_e; both saturate at all-ones.

Reset
REQ-027 SHALL, on asserted reset, asynchronously clear all valid bits, set all counters to 2^(CNT_W-1)-1, and zero both perf counters, so that pred_taken_f=0 and pred_target_f=pc_f+4 immediately.
REQ-028 SHALL discard any update occurring during reset; the first update takes effect on the first posedge after deassertion.

Structure
REQ-029 SHALL place the following in shared package bp_pkg:
- the entry struct, parameterised by tag and target width;
- the counter-init constants WEAK_NT and WEAK_T;
- IDX_W derivation helpers.
REQ-030 SHALL implement the counter update in one sub-module, sat_counter (width CNT_W; inc, dec, force-max, load).
REQ-031 SHALL reject illegal ENTRIES or CNT_W values with an elaboration-time assertion.

Verification
REQ-032 SHALL cover: after reset, pc_f=0x100 -> pred_taken_f=0, pred_target_f=0x104, both perf counters 0.
REQ-033 SHALL cover: update branch pc=0x40, taken, target=0x20, pred 0 -> mispredict_e=1, redirect_pc_e=0x20; next cycle pc_f=0x40 -> taken, 0x20, counter=2'b10.
REQ-034 SHALL cover: three not-taken updates at 0x40 -> counter 01, 00, 00 (saturates); pred_taken_f=0 after the first; perf_mispredicts counts each wrong prediction.
REQ-035 SHALL cover: aliasing with ENTRIES=64, pc_f=0x140 (same index as 0x40, different tag) -> miss, prediction 0x144; a jump update at 0x140 to 0x200 overwrites the entry and 0x40 then misses.
REQ-036 SHALL cover: update and lookup at 0x40 in the same cycle -> lookup shows old state, new state the following cycle.
REQ-037 SHALL cover: reset asserted mid-sequence between clock edges -> outputs not-taken immediately, perf counters 0.
